// File: rtl/imem_responder_if.sv
// Request/response bus between an instruction-memory initiator and imem_responder.
// Besides the request and response signals it carries a registered status
// snapshot that a simulation monitor can print whenever report is raised.
// The IMEM_RESPONDER_STATS_EN macro adds the read/write/stall counters to that
// snapshot.
interface imem_responder_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                    read;
  logic                    write;
  logic [ADDRESS_BITS-1:0] address;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [ADDRESS_BITS-1:0] out_addr;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    valid;
  logic                    ready;

  logic                    report_valid;
  logic [7:0]              report_core;
  logic [1:0]              report_state;
  logic [2:0]              report_occupancy;
  logic                    report_out_valid;
  logic                    report_ready;
`ifdef IMEM_RESPONDER_STATS_EN
  logic [31:0]             report_reads;
  logic [31:0]             report_writes;
  logic [31:0]             report_stalls;

  modport master (
    output read, write, address, in_data,
    input  out_addr, out_data, valid, ready,
    input  report_valid, report_core, report_state, report_occupancy,
    input  report_out_valid, report_ready,
    input  report_reads, report_writes, report_stalls
  );

  modport slave (
    input  read, write, address, in_data,
    output out_addr, out_data, valid, ready,
    output report_valid, report_core, report_state, report_occupancy,
    output report_out_valid, report_ready,
    output report_reads, report_writes, report_stalls
  );
`else
  modport master (
    output read, write, address, in_data,
    input  out_addr, out_data, valid, ready,
    input  report_valid, report_core, report_state, report_occupancy,
    input  report_out_valid, report_ready
  );

  modport slave (
    input  read, write, address, in_data,
    output out_addr, out_data, valid, ready,
    output report_valid, report_core, report_state, report_occupancy,
    output report_out_valid, report_ready
  );
`endif
endinterface

// File: rtl/imem_responder.sv
// imem_responder: word-addressed memory model with a 4-entry in-order request
// FIFO and a fixed LATENCY-cycle access FSM (IDLE -> ACCESS -> RESPOND).
// Reads return {out_addr, out_data} with a one-cycle valid strobe; writes are
// silent. read and write together count as a single write. Storage is indexed
// by the low INDEX_BITS of the address, so upper bits alias. The array is never
// cleared by reset.
// Optional feature macro: IMEM_RESPONDER_STATS_EN adds 32-bit read, write and
// stall counters to the status snapshot taken while report is high.
module imem_responder #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int INDEX_BITS   = 10,
  parameter int LATENCY      = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            report,
  imem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

  state_t state, next_state;
  logic [3:0] counter, next_counter;

  logic                    fifo_write [4];
  logic [ADDRESS_BITS-1:0] fifo_addr  [4];
  logic [DATA_WIDTH-1:0]   fifo_data  [4];
  logic [1:0]              wr_ptr;
  logic [1:0]              rd_ptr;
  logic [2:0]              count;

  logic                    cur_write;
  logic [ADDRESS_BITS-1:0] cur_addr;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic [INDEX_BITS-1:0]   cur_index;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    ready_int;
  logic                    push;
  logic                    pop;
  logic                    fifo_nonempty;
  logic                    access_done;
  logic                    valid_q;
  logic [ADDRESS_BITS-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0]   out_data_q;

  assign ready_int     = (count != 3'd4);
  assign fifo_nonempty = (count != 3'd0);
  assign push          = ready_int & (bus.read | bus.write);
  assign cur_index     = cur_addr[INDEX_BITS-1:0];

  assign bus.ready     = ready_int;
  assign bus.valid     = valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;

  // FSM state and latency down-counter registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= 4'd0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
    end
  end

  // Next-state logic: pop the FIFO head whenever idle or finishing a response
  always_comb begin
    next_state   = state;
    next_counter = counter;
    pop          = 1'b0;
    access_done  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          next_state   = ACCESS;
          next_counter = LOAD_COUNT;
          pop          = 1'b1;
        end
      end
      ACCESS: begin
        if (counter != 4'd0) begin
          next_counter = counter - 4'd1;
        end else begin
          access_done = 1'b1;
          next_state  = RESPOND;
        end
      end
      RESPOND: begin
        if (fifo_nonempty) begin
          next_state   = ACCESS;
          next_counter = LOAD_COUNT;
          pop          = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  // FIFO entry storage; a dual strobe is recorded as a write
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_write[wr_ptr] <= bus.write;
      fifo_addr[wr_ptr]  <= bus.address;
      fifo_data[wr_ptr]  <= bus.in_data;
    end
  end

  // Request currently being serviced, captured from the FIFO head on pop
  always_ff @(posedge clock) begin
    if (!reset) begin
      cur_write <= 1'b0;
      cur_addr  <= '0;
      cur_data  <= '0;
    end else if (pop) begin
      cur_write <= fifo_write[rd_ptr];
      cur_addr  <= fifo_addr[rd_ptr];
      cur_data  <= fifo_data[rd_ptr];
    end
  end

  // Array write at the end of the access; suppressed on a reset edge
  always_ff @(posedge clock) begin
    if (reset && access_done && cur_write) begin
      mem[cur_index] <= cur_data;
    end
  end

  // Read response registers; data and address hold until the next read response
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      valid_q <= access_done & ~cur_write;
      if (access_done && !cur_write) begin
        out_addr_q <= cur_addr;
        out_data_q <= mem[cur_index];
      end
    end
  end

`ifdef IMEM_RESPONDER_STATS_EN
  logic [31:0] stat_reads;
  logic [31:0] stat_writes;
  logic [31:0] stat_stalls;

  // Activity counters: accepted reads, accepted writes and refused request cycles
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_reads  <= 32'd0;
      stat_writes <= 32'd0;
      stat_stalls <= 32'd0;
    end else begin
      if (push && bus.read && !bus.write) stat_reads <= stat_reads + 32'd1;
      if (push && bus.write) stat_writes <= stat_writes + 32'd1;
      if ((bus.read || bus.write) && !ready_int) stat_stalls <= stat_stalls + 32'd1;
    end
  end

  // Status snapshot with counters, refreshed on every cycle report is high
  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.report_valid     <= 1'b0;
      bus.report_core      <= 8'd0;
      bus.report_state     <= 2'd0;
      bus.report_occupancy <= 3'd0;
      bus.report_out_valid <= 1'b0;
      bus.report_ready     <= 1'b0;
      bus.report_reads     <= 32'd0;
      bus.report_writes    <= 32'd0;
      bus.report_stalls    <= 32'd0;
    end else begin
      bus.report_valid <= report;
      if (report) begin
        bus.report_core      <= 8'(CORE);
        bus.report_state     <= state;
        bus.report_occupancy <= count;
        bus.report_out_valid <= valid_q;
        bus.report_ready     <= ready_int;
        bus.report_reads     <= stat_reads;
        bus.report_writes    <= stat_writes;
        bus.report_stalls    <= stat_stalls;
      end
    end
  end
`else
  // Status snapshot of FSM state, occupancy, valid and ready while report is high
  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.report_valid     <= 1'b0;
      bus.report_core      <= 8'd0;
      bus.report_state     <= 2'd0;
      bus.report_occupancy <= 3'd0;
      bus.report_out_valid <= 1'b0;
      bus.report_ready     <= 1'b0;
    end else begin
      bus.report_valid <= report;
      if (report) begin
        bus.report_core      <= 8'(CORE);
        bus.report_state     <= state;
        bus.report_occupancy <= count;
        bus.report_out_valid <= valid_q;
        bus.report_ready     <= ready_int;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (LATENCY=2, INDEX_BITS=10).
// A negedge monitor records every read response with the cycle it appeared in;
// stimulus tasks drive requests at the negedge and wait for acceptance.
module tb_imem_responder;

  logic clock;
  logic reset;
  logic report;
  int   cycle;
  int   vectors;
  int   miscompares;

  logic [31:0] respData [$];
  logic [19:0] respAddr [$];
  int          respCycle [$];
  logic        readyLowSeen;

  imem_responder_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) bus ();

  imem_responder #(
    .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .INDEX_BITS(10), .LATENCY(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .report(report),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Rising-edge counter used to time responses against acceptance
  always @(posedge clock) cycle <= cycle + 1;

  // Response recorder, ready watcher and status printer, all at the negedge
  always @(negedge clock) begin
    if (bus.valid === 1'b1) begin
      respData.push_back(bus.out_data);
      respAddr.push_back(bus.out_addr);
      respCycle.push_back(cycle);
    end
    if (bus.ready === 1'b0) readyLowSeen = 1'b1;
    if (bus.report_valid === 1'b1) begin
`ifdef IMEM_RESPONDER_STATS_EN
      $display("[TB] core %0d state %0d occupancy %0d valid %0b ready %0b reads %0d writes %0d stalls %0d",
               bus.report_core, bus.report_state, bus.report_occupancy, bus.report_out_valid,
               bus.report_ready, bus.report_reads, bus.report_writes, bus.report_stalls);
`else
      $display("[TB] core %0d state %0d occupancy %0d valid %0b ready %0b",
               bus.report_core, bus.report_state, bus.report_occupancy, bus.report_out_valid,
               bus.report_ready);
`endif
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive a request at the negedge and hold it until the edge that accepts it;
  // the request stays asserted afterwards until idleBus is called
  task automatic applyStimulus(input logic rd, input logic wr, input logic [19:0] addr,
                               input logic [31:0] data, output int accCycle);
    bus.read    = rd;
    bus.write   = wr;
    bus.address = addr;
    bus.in_data = data;
    accCycle    = -1;
    for (int i = 0; i < 50; i++) begin
      if (bus.ready === 1'b1) begin
        accCycle = cycle + 1;
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    if (accCycle < 0) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idleBus();
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic clearResponses();
    respData.delete();
    respAddr.delete();
    respCycle.delete();
  endtask

  task automatic waitResponses(input int n, input int budget);
    for (int i = 0; i < budget && respData.size() < n; i++) @(negedge clock);
  endtask

  initial begin
    int acc;
    int accFirst;
    cycle        = 0;
    vectors      = 0;
    miscompares  = 0;
    readyLowSeen = 1'b0;
    reset        = 1'b0;
    report       = 1'b0;
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.address  = '0;
    bus.in_data  = '0;

    // Reset held low for two cycles
    repeat (2) @(negedge clock);
    checkOutput("reset_valid", 64'(bus.valid), 64'd0);
    checkOutput("reset_out_data", 64'(bus.out_data), 64'd0);
    checkOutput("reset_out_addr", 64'(bus.out_addr), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_ready", 64'(bus.ready), 64'd1);

    // Write then read the same word
    clearResponses();
    applyStimulus(1'b0, 1'b1, 20'h00010, 32'hDEADBEEF, acc);
    idleBus();
    repeat (8) @(negedge clock);
    checkOutput("write_no_valid", 64'(respData.size()), 64'd0);
    applyStimulus(1'b1, 1'b0, 20'h00010, 32'h0, acc);
    idleBus();
    waitResponses(1, 12);
    checkOutput("rd_count", 64'(respData.size()), 64'd1);
    if (respData.size() >= 1) begin
      checkOutput("rd_latency", 64'(respCycle[0] - acc), 64'd3);
      checkOutput("rd_addr", 64'(respAddr[0]), 64'h10);
      checkOutput("rd_data", 64'(respData[0]), 64'hDEADBEEF);
    end
    repeat (3) @(negedge clock);
    checkOutput("rd_valid_one_cycle", 64'(respData.size()), 64'd1);
    checkOutput("rd_hold_data", 64'(bus.out_data), 64'hDEADBEEF);

    // Back-pressure: preload 0..5, then hold read asserted across six addresses
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 20'(i), 32'hA0 + 32'(i), acc);
    idleBus();
    repeat (25) @(negedge clock);
    clearResponses();
    readyLowSeen = 1'b0;
    accFirst = 0;
    report = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 20'(i), 32'h0, acc);
      if (i == 0) accFirst = acc;
    end
    report = 1'b0;
    idleBus();
    waitResponses(6, 40);
    repeat (6) @(negedge clock);
    checkOutput("bp_ready_dropped", 64'(readyLowSeen), 64'd1);
    checkOutput("bp_count", 64'(respData.size()), 64'd6);
    if (respData.size() == 6) begin
      checkOutput("bp_first_latency", 64'(respCycle[0] - accFirst), 64'd3);
      for (int i = 0; i < 6; i++) begin
        checkOutput($sformatf("bp_addr%0d", i), 64'(respAddr[i]), 64'(i));
        checkOutput($sformatf("bp_data%0d", i), 64'(respData[i]), 64'hA0 + 64'(i));
        if (i > 0) checkOutput($sformatf("bp_spacing%0d", i), 64'(respCycle[i] - respCycle[i-1]), 64'd3);
      end
    end

    // Simultaneous read and write strobes act as one write
    clearResponses();
    applyStimulus(1'b1, 1'b1, 20'h00020, 32'h55, acc);
    idleBus();
    repeat (8) @(negedge clock);
    checkOutput("dual_no_valid", 64'(respData.size()), 64'd0);
    applyStimulus(1'b1, 1'b0, 20'h00020, 32'h0, acc);
    idleBus();
    waitResponses(1, 12);
    checkOutput("dual_count", 64'(respData.size()), 64'd1);
    if (respData.size() >= 1) begin
      checkOutput("dual_addr", 64'(respAddr[0]), 64'h20);
      checkOutput("dual_data", 64'(respData[0]), 64'h55);
    end

    // Upper address bits alias onto the same word
    clearResponses();
    applyStimulus(1'b0, 1'b1, 20'h00400, 32'h1234, acc);
    idleBus();
    repeat (6) @(negedge clock);
    applyStimulus(1'b1, 1'b0, 20'h00000, 32'h0, acc);
    idleBus();
    waitResponses(1, 12);
    checkOutput("alias_count", 64'(respData.size()), 64'd1);
    if (respData.size() >= 1) begin
      checkOutput("alias_addr", 64'(respAddr[0]), 64'h0);
      checkOutput("alias_data", 64'(respData[0]), 64'h1234);
    end

    // Reset while in ACCESS with two reads still queued
    repeat (4) @(negedge clock);
    clearResponses();
    applyStimulus(1'b1, 1'b0, 20'h00001, 32'h0, acc);
    applyStimulus(1'b1, 1'b0, 20'h00002, 32'h0, acc);
    applyStimulus(1'b1, 1'b0, 20'h00003, 32'h0, acc);
    idleBus();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    checkOutput("midrst_no_valid", 64'(respData.size()), 64'd0);
    checkOutput("midrst_ready", 64'(bus.ready), 64'd1);
    checkOutput("midrst_out_data", 64'(bus.out_data), 64'd0);

    // Array contents survive reset
    applyStimulus(1'b1, 1'b0, 20'h00010, 32'h0, acc);
    idleBus();
    waitResponses(1, 12);
    checkOutput("keep_count", 64'(respData.size()), 64'd1);
    if (respData.size() >= 1) checkOutput("keep_data", 64'(respData[0]), 64'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter CORE, default 0, core index printed in report output.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 SHALL have parameter ADDRESS_BITS, default 20, word-address width.
REQ-004 SHALL have parameter INDEX_BITS, default 10, log2 of storage depth in words.
REQ-005 SHALL have parameter LATENCY, default 2, access cycles per request, legal range 1..15.
REQ-006 SHALL have port clock, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, synchronous, active-low reset.
REQ-008 SHALL have port read, input, 1 bit, read request strobe.
REQ-009 SHALL have port write, input, 1 bit, write request strobe.
REQ-010 SHALL have port address, input, ADDRESS_BITS, word address of the request.
REQ-011 SHALL have port in_data, input, DATA_WIDTH, write data.
REQ-012 SHALL have port report, input, 1 bit, status print enable for simulation.
REQ-013 SHALL have port out_addr, output, ADDRESS_BITS, word address of the returned read.
REQ-014 SHALL have port out_data, output, DATA_WIDTH, returned read data.
REQ-015 SHALL have port valid, output, 1 bit, one-cycle read-response strobe.
REQ-016 SHALL have port ready, output, 1 bit, request-acceptance indicator.

Function
REQ-017 SHALL accept a request on an edge where ready=1 and (read|write)=1; requests with ready=0 are dropped and the initiator must hold them.
REQ-018 SHALL queue accepted requests in an in-order 4-entry FIFO holding {is_write, address, in_data}.
REQ-019 SHALL drive ready=1 iff FIFO occupancy < 4, decoded from registered state only, with no combinational path from read, write or address.
REQ-020 SHALL let an enqueue and a dequeue happen on the same edge, leaving occupancy unchanged.
REQ-021 SHALL treat read=1 and write=1 together as a single write; no read response is produced.
REQ-022 SHALL index storage with address[INDEX_BITS-1:0]; upper address bits alias (wrap).
REQ-023 SHALL run FSM states IDLE, ACCESS and RESPOND.
REQ-024 SHALL go IDLE->ACCESS on any edge where the FIFO is non-empty, popping the head and loading the down-counter with LATENCY-1.
REQ-025 SHALL, in ACCESS with counter>0, decrement the counter; with counter=0, perform the array access and go to RESPOND.
REQ-026 SHALL commit a write to the array at the ACCESS-exit edge, with valid staying 0.
REQ-027 SHALL, for a read, register out_data and out_addr (the original full address) at the ACCESS-exit edge and hold valid=1 for exactly the RESPOND cycle.
REQ-028 SHALL leave RESPOND to ACCESS (popping) if the FIFO is non-empty, else to IDLE; sustained throughput is one request per LATENCY+1 cycles.
REQ-029 SHALL raise valid LATENCY+1 edges after the accepting edge when the FIFO and FSM were idle at acceptance.
REQ-030 SHALL hold out_data and out_addr after valid drops, until the next read response.
REQ-031 SHALL make a read that follows a write to the same address, in FIFO order, return the written data.

Reset
REQ-032 SHALL, on an edge with reset=0: FSM->IDLE, FIFO emptied, counter=0, valid=0, out_data=0, out_addr=0; ready=1 from the next cycle.
REQ-033 SHALL discard in-flight and queued requests on reset mid-operation, with no valid afterwards and no array write for them.
REQ-034 SHALL NOT reset array contents.

Configuration
REQ-035 SHALL, with IMEM_RESPONDER_STATS_EN defined, keep 32-bit counters of reads, writes and stall cycles (request asserted, ready=0), cleared by reset.
REQ-036 SHALL, with IMEM_RESPONDER_STATS_EN defined, print those counters, FSM state and occupancy each cycle report=1.
REQ-037 SHALL, without IMEM_RESPONDER_STATS_EN, omit the counters, keep the print limited to FSM state, occupancy, valid and ready, and leave all port behaviour identical.

Verification (LATENCY=2, INDEX_BITS=10)
REQ-038 SHALL check reset: reset=0 for 2 cycles -> valid=0, out_data=0, out_addr=0, then ready=1.
REQ-039 SHALL check write-then-read: write 0x10 <- 0xDEADBEEF, idle, then read 0x10 -> valid high exactly 3 edges after acceptance, out_addr=0x10, out_data=0xDEADBEEF.
REQ-040 SHALL check back-pressure: read held high over addresses 0..5 preloaded with 0xA0..0xA5 -> ready drops to 0 at least once; six responses arrive in order at 3-cycle spacing; none lost or duplicated.
REQ-041 SHALL check simultaneous strobes: read=write=1, address 0x20, in_data 0x55 -> no valid; a later read of 0x20 returns 0x55.
REQ-042 SHALL check aliasing: write 0x400 <- 0x1234, then read 0x000 -> out_data=0x1234, out_addr=0x000.
REQ-043 SHALL check reset mid-access: reset=0 while in ACCESS with 2 queued reads -> no valid for 10 cycles after release, ready=1.
